// File: rtl/rgb_level_scheduler.sv
// -----------------------------------------------------------------------------
// rgb_level_scheduler
//
// Owns the three PWM duty-level registers of the RGB mixer. Manual mode takes
// per-channel increment/decrement pulses from the encoder decoders, parks each
// in a one-deep pending slot, and a round-robin arbiter feeds one slot per
// cycle into a single shared saturating adder. Auto mode replaces encoder
// control with a fade sequencer that ramps each channel up to MAX and back
// down to 0, then moves on to the next channel.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   inc[2:0]   one-cycle increment pulse per channel
//   dec[2:0]   one-cycle decrement pulse per channel
//   auto_mode  1 = auto-fade, 0 = manual encoder control
//   step_tick  fade-rate strobe, only used in auto mode
//   level0..2  channel duty levels
//   grant[2:0] registered one-hot of the channel updated this cycle, 0 if none
//   busy       registered OR of all pending manual slots
//   drop       one-cycle pulse when a manual request was discarded
// -----------------------------------------------------------------------------
module rgb_level_scheduler #(
    parameter int WIDTH     = 8,
    parameter int STEP      = 1,
    parameter int FADE_STEP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       inc,
    input  logic [2:0]       dec,
    input  logic             auto_mode,
    input  logic             step_tick,
    output logic [WIDTH-1:0] level0,
    output logic [WIDTH-1:0] level1,
    output logic [WIDTH-1:0] level2,
    output logic [2:0]       grant,
    output logic             busy,
    output logic             drop
);

    // FSM encoding kept as plain constants for compatibility with older tools
    localparam logic [1:0] ST_MANUAL    = 2'd0;
    localparam logic [1:0] ST_RAMP_UP   = 2'd1;
    localparam logic [1:0] ST_RAMP_DOWN = 2'd2;

    // Pending slot contents
    localparam logic [1:0] DIR_NONE = 2'd0;
    localparam logic [1:0] DIR_UP   = 2'd1;
    localparam logic [1:0] DIR_DOWN = 2'd2;

    // Adder operates one bit wider than the levels so overflow/borrow is visible
    localparam logic [WIDTH:0] MAX_EXT       = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0] STEP_EXT      = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] FADE_STEP_EXT = (WIDTH+1)'(FADE_STEP);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] level_q [3];
    logic [1:0]       pend_q  [3];
    logic [1:0]       ptr_q;
    logic [1:0]       state_q;
    logic [1:0]       fade_ch_q;
    logic [2:0]       grant_q;
    logic             busy_q;
    logic             drop_q;

    // -------------------------------------------------------------------------
    // Next-state signals
    // -------------------------------------------------------------------------
    logic [1:0]       pend_n  [3];
    logic [1:0]       ptr_n;
    logic [1:0]       state_n;
    logic [1:0]       fade_ch_n;
    logic [2:0]       grant_n;
    logic             busy_n;
    logic             drop_n;

    // Arbiter result
    logic             arb_hit;
    logic [1:0]       arb_ch;
    int unsigned      arb_idx;

    // Shared adder control and datapath
    logic             upd_en;
    logic [1:0]       upd_ch;
    logic             upd_up;
    logic [WIDTH:0]   upd_amt;
    logic [WIDTH:0]   upd_opnd;
    logic [WIDTH:0]   upd_sum;
    logic [WIDTH:0]   upd_diff;
    logic [WIDTH-1:0] upd_res;

    // Manual capture helpers
    logic             manual_active;
    logic             req_up;
    logic             req_dn;
    logic             slot_granted;
    logic             slot_blocked;

    // -------------------------------------------------------------------------
    // Round-robin arbiter: first non-empty slot searching upward from ptr_q
    // -------------------------------------------------------------------------
    always_comb begin
        arb_hit = 1'b0;
        arb_ch  = 2'd0;
        arb_idx = 0;
        for (int unsigned k = 0; k < 3; k++) begin
            arb_idx = (32'(ptr_q) + k) % 3;
            if (!arb_hit && pend_q[arb_idx] != DIR_NONE) begin
                arb_hit = 1'b1;
                arb_ch  = arb_idx[1:0];
            end
        end
    end

    // Manual requests are only honoured in MANUAL while auto_mode stays low;
    // the edge that enters auto mode already ignores inc/dec and grants.
    assign manual_active = (state_q == ST_MANUAL) && !auto_mode;

    // -------------------------------------------------------------------------
    // Update source select: arbiter in manual mode, fade sequencer in auto
    // -------------------------------------------------------------------------
    always_comb begin
        upd_en  = 1'b0;
        upd_ch  = 2'd0;
        upd_up  = 1'b0;
        upd_amt = STEP_EXT;
        case (state_q)
            ST_MANUAL: begin
                if (manual_active && arb_hit) begin
                    upd_en = 1'b1;
                    upd_ch = arb_ch;
                    upd_up = (pend_q[arb_ch] == DIR_UP);
                end
            end
            ST_RAMP_UP: begin
                if (auto_mode && step_tick) begin
                    upd_en  = 1'b1;
                    upd_ch  = fade_ch_q;
                    upd_up  = 1'b1;
                    upd_amt = FADE_STEP_EXT;
                end
            end
            ST_RAMP_DOWN: begin
                if (auto_mode && step_tick) begin
                    upd_en  = 1'b1;
                    upd_ch  = fade_ch_q;
                    upd_up  = 1'b0;
                    upd_amt = FADE_STEP_EXT;
                end
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Shared saturating adder
    // -------------------------------------------------------------------------
    always_comb begin
        case (upd_ch)
            2'd1:    upd_opnd = {1'b0, level_q[1]};
            2'd2:    upd_opnd = {1'b0, level_q[2]};
            default: upd_opnd = {1'b0, level_q[0]};
        endcase
        upd_sum  = upd_opnd + upd_amt;
        upd_diff = upd_opnd - upd_amt;
        if (upd_up) begin
            upd_res = (upd_sum > MAX_EXT) ? MAX_EXT[WIDTH-1:0] : upd_sum[WIDTH-1:0];
        end else begin
            // Top bit set means the subtraction borrowed
            upd_res = upd_diff[WIDTH] ? '0 : upd_diff[WIDTH-1:0];
        end
    end

    // -------------------------------------------------------------------------
    // Pending slot capture, drop detection, pointer update
    // -------------------------------------------------------------------------
    always_comb begin
        drop_n       = 1'b0;
        req_up       = 1'b0;
        req_dn       = 1'b0;
        slot_granted = 1'b0;
        slot_blocked = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            pend_n[i] = DIR_NONE;
        end
        for (int unsigned i = 0; i < 3; i++) begin
            if (manual_active) begin
                req_up       = inc[i] && !dec[i];
                req_dn       = dec[i] && !inc[i];
                slot_granted = upd_en && (upd_ch == 2'(i));
                // A slot freed by this edge's grant can take a new request
                slot_blocked = (pend_q[i] != DIR_NONE) && !slot_granted;
                pend_n[i]    = slot_granted ? DIR_NONE : pend_q[i];
                if (req_up || req_dn) begin
                    if (slot_blocked) begin
                        drop_n = 1'b1;
                    end else begin
                        pend_n[i] = req_up ? DIR_UP : DIR_DOWN;
                    end
                end
            end
        end

        ptr_n = ptr_q;
        if (state_q == ST_MANUAL && upd_en) begin
            ptr_n = (upd_ch == 2'd2) ? 2'd0 : upd_ch + 2'd1;
        end

        busy_n = (pend_n[0] != DIR_NONE) || (pend_n[1] != DIR_NONE) ||
                 (pend_n[2] != DIR_NONE);
    end

    // -------------------------------------------------------------------------
    // Fade FSM
    // -------------------------------------------------------------------------
    always_comb begin
        state_n   = state_q;
        fade_ch_n = fade_ch_q;
        case (state_q)
            ST_MANUAL: begin
                if (auto_mode) begin
                    state_n   = ST_RAMP_UP;
                    fade_ch_n = 2'd0;
                end
            end
            ST_RAMP_UP: begin
                if (!auto_mode) begin
                    state_n = ST_MANUAL;
                end else if (step_tick && upd_res == MAX_EXT[WIDTH-1:0]) begin
                    state_n = ST_RAMP_DOWN;
                end
            end
            ST_RAMP_DOWN: begin
                if (!auto_mode) begin
                    state_n = ST_MANUAL;
                end else if (step_tick && upd_res == '0) begin
                    state_n   = ST_RAMP_UP;
                    fade_ch_n = (fade_ch_q == 2'd2) ? 2'd0 : fade_ch_q + 2'd1;
                end
            end
            default: state_n = ST_MANUAL;
        endcase
    end

    always_comb begin
        grant_n = '0;
        if (upd_en) begin
            grant_n[upd_ch] = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 3; i++) begin
                level_q[i] <= '0;
                pend_q[i]  <= DIR_NONE;
            end
            ptr_q     <= '0;
            state_q   <= ST_MANUAL;
            fade_ch_q <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (upd_en && upd_ch == 2'(i)) begin
                    level_q[i] <= upd_res;
                end
                pend_q[i] <= pend_n[i];
            end
            ptr_q     <= ptr_n;
            state_q   <= state_n;
            fade_ch_q <= fade_ch_n;
            grant_q   <= grant_n;
            busy_q    <= busy_n;
            drop_q    <= drop_n;
        end
    end

    assign level0 = level_q[0];
    assign level1 = level_q[1];
    assign level2 = level_q[2];
    assign grant  = grant_q;
    assign busy   = busy_q;
    assign drop   = drop_q;

endmodule

// File: tb/tb_rgb_level_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rgb_level_scheduler
//
// Directed checks of rgb_level_scheduler: a table of single-cycle vectors
// (inputs plus expected outputs after the edge) covering reset, single and
// simultaneous requests, round-robin order, no-op, saturation at 0, drop and
// refill; then hand-written sequences for upper saturation, the auto-fade
// ramp and leaving auto mode mid-ramp.
// -----------------------------------------------------------------------------
module tb_rgb_level_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] inc = '0;
    logic [2:0] dec = '0;
    logic       auto_mode = 1'b0;
    logic       step_tick = 1'b0;
    logic [7:0] level0, level1, level2;
    logic [2:0] grant;
    logic       busy, drop;

    int total = 0;
    int bad   = 0;

    rgb_level_scheduler #(.WIDTH(8), .STEP(1), .FADE_STEP(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (inc),
        .dec       (dec),
        .auto_mode (auto_mode),
        .step_tick (step_tick),
        .level0    (level0),
        .level1    (level1),
        .level2    (level2),
        .grant     (grant),
        .busy      (busy),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [2:0] inc;
        logic [2:0] dec;
        logic [7:0] l0, l1, l2;
        logic [2:0] g;
        logic       b, d;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic [2:0] i, input logic [2:0] d,
                                input int l0, input int l1, input int l2,
                                input logic [2:0] g, input logic b, input logic dr);
        vec_t v;
        v.rst = rst; v.inc = i; v.dec = d;
        v.l0 = 8'(l0); v.l1 = 8'(l1); v.l2 = 8'(l2);
        v.g = g; v.b = b; v.d = dr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; inc = '0; dec = '0; auto_mode = 1'b0; step_tick = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    int exp_l;
    logic drop_seen;

    initial begin
        // rst inc   dec    l0 l1 l2  grant  busy drop
        vecs.push_back(mk(1, 3'b000, 3'b000, 0, 0, 0, 3'b000, 0, 0)); // reset
        vecs.push_back(mk(0, 3'b001, 3'b000, 0, 0, 0, 3'b000, 1, 0)); // inc0 captured
        vecs.push_back(mk(0, 3'b000, 3'b000, 1, 0, 0, 3'b001, 0, 0)); // granted
        vecs.push_back(mk(0, 3'b000, 3'b000, 1, 0, 0, 3'b000, 0, 0)); // idle
        vecs.push_back(mk(1, 3'b000, 3'b000, 0, 0, 0, 3'b000, 0, 0)); // reset
        vecs.push_back(mk(0, 3'b111, 3'b000, 0, 0, 0, 3'b000, 1, 0)); // all three
        vecs.push_back(mk(0, 3'b000, 3'b000, 1, 0, 0, 3'b001, 1, 0));
        vecs.push_back(mk(0, 3'b000, 3'b000, 1, 1, 0, 3'b010, 1, 0));
        vecs.push_back(mk(0, 3'b000, 3'b000, 1, 1, 1, 3'b100, 0, 0)); // ptr -> 0
        vecs.push_back(mk(0, 3'b101, 3'b000, 1, 1, 1, 3'b000, 1, 0)); // ch0 & ch2
        vecs.push_back(mk(0, 3'b000, 3'b000, 2, 1, 1, 3'b001, 1, 0)); // ch0 first
        vecs.push_back(mk(0, 3'b000, 3'b000, 2, 1, 2, 3'b100, 0, 0));
        vecs.push_back(mk(0, 3'b001, 3'b001, 2, 1, 2, 3'b000, 0, 0)); // inc&dec no-op
        vecs.push_back(mk(0, 3'b000, 3'b010, 2, 1, 2, 3'b000, 1, 0)); // dec1
        vecs.push_back(mk(0, 3'b000, 3'b000, 2, 0, 2, 3'b010, 0, 0));
        vecs.push_back(mk(0, 3'b000, 3'b010, 2, 0, 2, 3'b000, 1, 0)); // dec1 at 0
        vecs.push_back(mk(0, 3'b000, 3'b000, 2, 0, 2, 3'b010, 0, 0)); // stays 0
        vecs.push_back(mk(1, 3'b000, 3'b000, 0, 0, 0, 3'b000, 0, 0)); // reset
        vecs.push_back(mk(0, 3'b111, 3'b000, 0, 0, 0, 3'b000, 1, 0));
        vecs.push_back(mk(0, 3'b100, 3'b000, 1, 0, 0, 3'b001, 1, 1)); // inc2 dropped
        vecs.push_back(mk(0, 3'b000, 3'b000, 1, 1, 0, 3'b010, 1, 0));
        vecs.push_back(mk(0, 3'b000, 3'b000, 1, 1, 1, 3'b100, 0, 0)); // level2 = 1
        vecs.push_back(mk(0, 3'b001, 3'b000, 1, 1, 1, 3'b000, 1, 0));
        vecs.push_back(mk(0, 3'b001, 3'b000, 2, 1, 1, 3'b001, 1, 0)); // refill on grant
        vecs.push_back(mk(0, 3'b000, 3'b000, 3, 1, 1, 3'b001, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            inc = vecs[i].inc;
            dec = vecs[i].dec;
            if (vecs[i].rst) rst_n = 1'b0;
            cyc();
            rst_n = 1'b1;
            inc = '0;
            dec = '0;
            chk($sformatf("v%0d.level0", i), 32'(level0), 32'(vecs[i].l0));
            chk($sformatf("v%0d.level1", i), 32'(level1), 32'(vecs[i].l1));
            chk($sformatf("v%0d.level2", i), 32'(level2), 32'(vecs[i].l2));
            chk($sformatf("v%0d.grant", i),  32'(grant),  32'(vecs[i].g));
            chk($sformatf("v%0d.busy", i),   32'(busy),   32'(vecs[i].b));
            chk($sformatf("v%0d.drop", i),   32'(drop),   32'(vecs[i].d));
        end

        // Upper saturation on channel 1, then decrement through to 0
        do_reset();
        drop_seen = 1'b0;
        for (int i = 0; i < 255; i++) begin
            inc = 3'b010;
            cyc();
            drop_seen = drop_seen | drop;
        end
        inc = '0;
        cyc();
        chk("sat.preload", 32'(level1), 32'd255);
        chk("sat.no_drop", 32'(drop_seen), 32'd0);
        inc = 3'b010;
        cyc();
        inc = '0;
        cyc();
        chk("sat.grant", 32'(grant), 32'b010);
        chk("sat.hold255", 32'(level1), 32'd255);
        for (int j = 1; j <= 256; j++) begin
            dec = 3'b010;
            cyc();
            exp_l = 255 - (j - 1);
            if (exp_l < 0) exp_l = 0;
            chk($sformatf("sat.dec%0d", j), 32'(level1), 32'(exp_l));
        end
        dec = '0;
        cyc();
        chk("sat.zero", 32'(level1), 32'd0);
        chk("sat.idle_busy", 32'(busy), 32'd0);

        // Auto fade: ramp channel 0 up and down, then channel 1 starts
        do_reset();
        auto_mode = 1'b1;
        cyc();
        chk("auto.entry_grant", 32'(grant), 32'd0);
        for (int t = 1; t <= 129; t++) begin
            step_tick = 1'b1;
            cyc();
            step_tick = 1'b0;
            if (t <= 64) begin
                exp_l = (4 * t > 255) ? 255 : 4 * t;
                chk($sformatf("auto.up%0d", t), 32'(level0), 32'(exp_l));
                chk($sformatf("auto.up%0d.grant", t), 32'(grant), 32'b001);
            end else if (t <= 128) begin
                exp_l = 255 - 4 * (t - 64);
                if (exp_l < 0) exp_l = 0;
                chk($sformatf("auto.dn%0d", t), 32'(level0), 32'(exp_l));
            end else begin
                chk("auto.ch1_level", 32'(level1), 32'd4);
                chk("auto.ch1_grant", 32'(grant), 32'b010);
                chk("auto.ch0_rest", 32'(level0), 32'd0);
            end
            for (int k = 0; k < 3; k++) cyc();
            if (t == 1) chk("auto.grant_idle", 32'(grant), 32'd0);
        end

        // Leave auto mode mid-ramp
        do_reset();
        auto_mode = 1'b1;
        cyc();
        for (int t = 0; t < 25; t++) begin
            step_tick = 1'b1;
            cyc();
            step_tick = 1'b0;
            cyc();
        end
        chk("abort.level100", 32'(level0), 32'd100);
        inc = 3'b111;
        cyc();
        inc = '0;
        chk("abort.inc_ignored_busy", 32'(busy), 32'd0);
        chk("abort.inc_ignored_grant", 32'(grant), 32'd0);
        auto_mode = 1'b0;
        step_tick = 1'b1;
        cyc();
        step_tick = 1'b0;
        chk("abort.exit_hold", 32'(level0), 32'd100);
        chk("abort.exit_grant", 32'(grant), 32'd0);
        inc = 3'b001;
        cyc();
        inc = '0;
        cyc();
        chk("abort.manual_inc", 32'(level0), 32'd101);
        chk("abort.manual_grant", 32'(grant), 32'b001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
